dispensador_cartas: RTL and testbench

DISPENSADOR_CARTAS -- requirements
Module: dispensador_cartas

---
 rtl/blackjack_pkg.sv | 31 +++
 rtl/lfsr16.sv | 26 ++
 rtl/dispensador_cartas.sv | 103 ++++++++++
 tb/tb_dispensador_cartas.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared constants, state encoding and helpers for the blackjack card dispenser.
package blackjack_pkg;

  localparam int unsigned NUM_CARTAS = 52;
  localparam int unsigned NUM_RANKS  = 13;

  // Feedback taps 16,14,13,11 mapped onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ESPERA       = 2'd0,
    EMBARALHANDO = 2'd1,
    PRONTO       = 2'd2
  } estado_t;

  function automatic logic [3:0] rank_para_valor(input logic [3:0] rank);
    if (rank == 4'd0) begin
      return 4'd1;
    end else if (rank <= 4'd9) begin
      return rank + 4'd1;
    end else begin
      return 4'd10;
    end
  endfunction

  // Smallest all-ones mask covering i: smear the top set bit downwards.
  function automatic logic [5:0] mascara_indice(input logic [5:0] i);
    return i | (i >> 1) | (i >> 2) | (i >> 3) | (i >> 4) | (i >> 5);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with the seed on reset.
module lfsr16
  import blackjack_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb;

  assign fb = ^(q_q & LFSR_TAPS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= seed;
    end else begin
      q_q <= {q_q[14:0], fb};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dispensador_cartas.sv
// Card dispenser: Fisher-Yates shuffle of a 52-card deck driven by an LFSR, then
// deals one card per request cycle.
module dispensador_cartas
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       embaralhar_start,
  input  logic       pedido,
  output logic       embaralhar_ok,
  output logic [3:0] carta,
  output logic       carta_valida,
  output logic [5:0] cartas_restantes,
  output logic       baralho_vazio
);

  localparam logic [5:0] Total  = 6'(NUM_CARTAS);
  localparam logic [5:0] Ultima = 6'(NUM_CARTAS - 1);

  estado_t    estado_q;
  logic [3:0] deck_q [NUM_CARTAS];
  logic [5:0] ptr_q;
  logic [5:0] idx_q;
  logic [3:0] carta_q;
  logic       valida_q;
  logic       ok_q;
  logic [5:0] rest_q;
  logic       vazio_q;

  logic [15:0] lfsr;
  logic [5:0]  j;
  logic        troca;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Rejection sampling: a j beyond i is discarded and retried next cycle.
  assign j     = lfsr[5:0] & mascara_indice(idx_q);
  assign troca = (j <= idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= ESPERA;
      for (int p = 0; p < NUM_CARTAS; p++) begin
        deck_q[p] <= 4'(p % NUM_RANKS);
      end
      ptr_q    <= 6'd0;
      idx_q    <= Ultima;
      carta_q  <= 4'd0;
      valida_q <= 1'b0;
      ok_q     <= 1'b0;
      rest_q   <= 6'd0;
      vazio_q  <= 1'b0;
    end else begin
      valida_q <= 1'b0;
      unique case (estado_q)
        ESPERA, PRONTO: begin
          if (embaralhar_start) begin
            estado_q <= EMBARALHANDO;
            idx_q    <= Ultima;
            ptr_q    <= 6'd0;
            ok_q     <= 1'b0;
            rest_q   <= 6'd0;
            vazio_q  <= 1'b0;
          end else if (estado_q == PRONTO && pedido && ptr_q < Total) begin
            carta_q  <= rank_para_valor(deck_q[ptr_q]);
            valida_q <= 1'b1;
            ptr_q    <= ptr_q + 6'd1;
            rest_q   <= Total - ptr_q - 6'd1;
            vazio_q  <= (ptr_q == Ultima);
          end
        end
        EMBARALHANDO: begin
          if (troca) begin
            deck_q[idx_q] <= deck_q[j];
            deck_q[j]     <= deck_q[idx_q];
            idx_q         <= idx_q - 6'd1;
            if (idx_q == 6'd1) begin
              estado_q <= PRONTO;
              ok_q     <= 1'b1;
              rest_q   <= Total;
              vazio_q  <= 1'b0;
            end
          end
        end
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign embaralhar_ok    = ok_q;
  assign carta            = carta_q;
  assign carta_valida     = valida_q;
  assign cartas_restantes = rest_q;
  assign baralho_vazio    = vazio_q;

endmodule

// File: tb/tb_dispensador_cartas.sv
// Scoreboard bench for dispensador_cartas: driver queues expected cards, monitor checks pulses.
module tb_dispensador_cartas;

  localparam logic [15:0] Seed = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       embaralhar_start = 1'b0;
  logic       pedido = 1'b0;
  logic       embaralhar_ok;
  logic [3:0] carta;
  logic       carta_valida;
  logic [5:0] cartas_restantes;
  logic       baralho_vazio;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_q[$];
  int          hist[16];
  logic [3:0]  e_card;
  logic [15:0] m_lfsr;
  int          mdeck[52];
  int          mptr;

  dispensador_cartas #(
    .LFSR_SEED (Seed)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .embaralhar_start (embaralhar_start),
    .pedido           (pedido),
    .embaralhar_ok    (embaralhar_ok),
    .carta            (carta),
    .carta_valida     (carta_valida),
    .cartas_restantes (cartas_restantes),
    .baralho_vazio    (baralho_vazio)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [3:0] valor(input int rank);
    if (rank == 0) return 4'd1;
    if (rank < 10) return 4'(rank + 1);
    return 4'd10;
  endfunction

  // Reference LFSR, tracks the DUT's free-running register cycle by cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_lfsr <= Seed;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(negedge clock) begin
    if (reset && carta_valida) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: carta=%0d with no card expected", carta);
      end else begin
        e_card = exp_q.pop_front();
        if (carta !== e_card) begin
          errors++;
          $display("FAIL card_value: got %0d expected %0d", carta, e_card);
        end
      end
      hist[carta]++;
    end
  end

  task automatic check(input string nome, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, expv);
    end
  endtask

  task automatic reset_model();
    for (int p = 0; p < 52; p++) mdeck[p] = p % 13;
    mptr = 0;
  endtask

  // l0 is the LFSR value at the edge that samples embaralhar_start.
  task automatic model_shuffle(input logic [15:0] l0);
    logic [15:0] l;
    int i, jj, msk, t;
    l = lfsr_step(l0);
    i = 51;
    while (i > 0) begin
      msk = (i >= 32) ? 63 : (i >= 16) ? 31 : (i >= 8) ? 15 : (i >= 4) ? 7 : (i >= 2) ? 3 : 1;
      jj = int'(l[5:0]) & msk;
      if (jj <= i) begin
        t = mdeck[i];
        mdeck[i] = mdeck[jj];
        mdeck[jj] = t;
        i--;
      end
      l = lfsr_step(l);
    end
    mptr = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic start_shuffle(input logic with_pedido);
    model_shuffle(m_lfsr);
    embaralhar_start = 1'b1;
    pedido = with_pedido;
    @(negedge clock);
    embaralhar_start = 1'b0;
    pedido = 1'b0;
    check("ok_cleared_on_start", embaralhar_ok, 1'b0);
    check("no_pulse_on_start", carta_valida, 1'b0);
  endtask

  task automatic wait_ok();
    int n = 0;
    while (!embaralhar_ok && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("shuffle_done", embaralhar_ok, 1'b1);
    check("restantes_full", cartas_restantes, 16'd52);
    check("vazio_after_shuffle", baralho_vazio, 1'b0);
  endtask

  task automatic deal(input int n);
    for (int k = 0; k < n; k++) begin
      pedido = 1'b1;
      exp_q.push_back(valor(mdeck[mptr]));
      mptr++;
      @(negedge clock);
    end
    pedido = 1'b0;
  endtask

  task automatic check_hist();
    for (int v = 1; v <= 9; v++) check($sformatf("hist_%0d", v), 16'(hist[v]), 16'd4);
    check("hist_10", 16'(hist[10]), 16'd16);
  endtask

  task automatic clear_hist();
    for (int v = 0; v < 16; v++) hist[v] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_carta"}, carta, 4'd0);
    check({tag, "_valida"}, carta_valida, 1'b0);
    check({tag, "_ok"}, embaralhar_ok, 1'b0);
    check({tag, "_restantes"}, cartas_restantes, 6'd0);
    check({tag, "_vazio"}, baralho_vazio, 1'b0);
  endtask

  task automatic full_deal();
    clear_hist();
    deal(10);
    check("restantes_mid", cartas_restantes, 16'd42);
    check("vazio_mid", baralho_vazio, 1'b0);
    deal(42);
    check("restantes_end", cartas_restantes, 16'd0);
    check("vazio_end", baralho_vazio, 1'b1);
    @(negedge clock);
    check_hist();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    clear_hist();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Requests without a shuffle are ignored.
    for (int k = 0; k < 5; k++) begin
      pedido = 1'b1;
      @(negedge clock);
      check("espera_no_pulse", carta_valida, 1'b0);
    end
    pedido = 1'b0;
    check("espera_restantes", cartas_restantes, 6'd0);
    check("espera_ok", embaralhar_ok, 1'b0);

    repeat (3) @(negedge clock);
    start_shuffle(1'b0);
    // Requests and a repeated start while shuffling are ignored.
    for (int k = 0; k < 3; k++) begin
      pedido = 1'b1;
      @(negedge clock);
      check("shuffling_no_pulse", carta_valida, 1'b0);
    end
    pedido = 1'b0;
    embaralhar_start = 1'b1;
    @(negedge clock);
    embaralhar_start = 1'b0;
    wait_ok();
    full_deal();

    // 53rd request on an empty deck.
    pedido = 1'b1;
    @(negedge clock);
    pedido = 1'b0;
    check("empty_no_pulse", carta_valida, 1'b0);
    check("empty_carta_held", carta, valor(mdeck[51]));
    check("empty_restantes", cartas_restantes, 6'd0);
    check("empty_vazio", baralho_vazio, 1'b1);

    // Reshuffle from the current permutation; start beats a simultaneous request.
    @(negedge clock);
    start_shuffle(1'b0);
    wait_ok();
    deal(3);
    check("restantes_after3", cartas_restantes, 16'd49);
    start_shuffle(1'b1);
    wait_ok();
    full_deal();

    // Reset in the middle of a shuffle.
    @(negedge clock);
    start_shuffle(1'b0);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_model();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    start_shuffle(1'b0);
    wait_ok();
    full_deal();

    repeat (2) @(negedge clock);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
